phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have parameter NPHASE, default 5, meaning number of phases per instruction; legal range 2..8.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the retired-instruction counter.
REQ-003 SHALL have port clock  input  1  sole clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port exec  input  1  run/stop request level; a rising edge is the request.
REQ-006 SHALL have port step  input  1  single-step request level; a rising edge is the request.
REQ-007 SHALL have port halt  input  1  halt indication from the processor, sampled only in the last phase.
REQ-008 SHALL have port stall  input  1  freezes phase advance while high.
REQ-009 SHALL have port phase  output  4  binary index of the active phase, 0..NPHASE-1.
REQ-010 SHALL have port phase_bus  output  NPHASE  one-hot active phase; all-zero when not sequencing.
REQ-011 SHALL have port reset_ps  output  1  processor-state reset pulse.
REQ-012 SHALL have port running  output  1  high in RUN or STEP.
REQ-013 SHALL have port halted  output  1  high in HALT.
REQ-014 SHALL have port icount  output  CNT_W  retired-instruction count.

Function
REQ-015 SHALL implement states IDLE, RUN, STEP, HALT; all outputs registered.
REQ-016 SHALL detect edges as input high while previous registered sample low; previous samples reset to 1, so a level held across reset is not an edge.
REQ-017 SHALL, in IDLE, on exec edge, enter RUN with phase=0, phase_bus=one-hot bit 0 in the next cycle (1-cycle latency).
REQ-018 SHALL, in IDLE, on step edge without exec edge, enter STEP with phase=0; exec edge wins when both coincide.
REQ-019 SHALL, in RUN/STEP, advance phase by 1 per cycle when stall low, wrapping NPHASE-1 -> 0; stall high holds phase and phase_bus unchanged.
REQ-020 SHALL treat phase=NPHASE-1 with stall low as instruction completion: icount increments by 1, wrapping at 2^CNT_W-1 -> 0.
REQ-021 SHALL, at completion with halt high, enter HALT (phase_bus all-zero, phase=0); halt has priority over stop and step exit.
REQ-022 SHALL, at completion in STEP, return to IDLE.
REQ-023 SHALL, on exec edge in RUN, latch a stop request; RUN continues to completion of the current instruction, then goes to IDLE; stop request then clears.
REQ-024 SHALL ignore step edges in RUN, STEP and HALT, and exec edges in STEP.
REQ-025 SHALL, on exec edge in HALT, pulse reset_ps high for exactly one cycle, clear icount to 0, and enter RUN with phase=0 in the cycle after the pulse.
REQ-026 SHALL ignore halt and stall in IDLE and HALT.
REQ-027 SHALL keep phase_bus one-hot with bit index equal to phase whenever running is high.

Reset
REQ-028 SHALL, while reset is low at a clock edge, set state IDLE, phase=0, phase_bus=0, running=0, halted=0, icount=0, stop request cleared, edge samples=1, reset_ps=1.
REQ-029 SHALL drive reset_ps high for exactly one cycle after the first edge with reset high, then 0.
REQ-030 SHALL abandon any instruction in progress when reset is asserted mid-operation; no completion or icount update occurs.

Verification
REQ-031 SHALL verify: release reset, pulse exec -> phase_bus 00001,00010,00100,01000,10000,00001 on consecutive cycles; icount=1 after first 10000 cycle.
REQ-032 SHALL verify: RUN, stall high 3 cycles at phase=2 -> phase_bus stays 00100 three cycles, then 01000; icount increment delayed 3 cycles.
REQ-033 SHALL verify: step edge in IDLE -> exactly 5 phases, icount 0->1, running drops, phase_bus=0; second step repeats (icount=2).
REQ-034 SHALL verify: exec edge at phase=1 in RUN -> phases 2..4 complete, then IDLE with icount+1; halt high at phase=4 -> HALT, halted=1; exec edge -> reset_ps one cycle, icount=0, then phase_bus=00001.
REQ-035 SHALL verify: reset low at phase=3 -> next cycle all outputs at reset values; exec held high through reset release -> stays IDLE.
REQ-036 SHALL verify: icount preloaded by running to 16'hFFFF -> next completion gives 16'h0000.

Source files
------------

// File: rtl/phase_sequencer_if.sv
// Control/status bundle between a processor core and its phase sequencer.
// Latency: none, this is wiring only.
// Backpressure: stall from the master freezes the sequencer's phase advance.
interface phase_sequencer_if #(
  parameter int NPHASE = 5,
  parameter int CNT_W  = 16
);
  // requests and status from the processor side
  logic              exec;
  logic              step;
  logic              halt;
  logic              stall;
  // sequencer outputs
  logic [3:0]        phase;
  logic [NPHASE-1:0] phase_bus;
  logic              reset_ps;
  logic              running;
  logic              halted;
  logic [CNT_W-1:0]  icount;

  // processor / controlling side
  modport master (
    output exec, step, halt, stall,
    input  phase, phase_bus, reset_ps, running, halted, icount
  );

  // sequencer side
  modport slave (
    input  exec, step, halt, stall,
    output phase, phase_bus, reset_ps, running, halted, icount
  );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-phase instruction sequencer: run/step/halt control, one-hot phase strobes, retired count.
// Latency: one cycle from a sampled exec/step edge to the first phase; every output is registered.
// Backpressure: stall holds the current phase; halt is honoured only at instruction completion.
module phase_sequencer #(
  parameter int NPHASE = 5,
  parameter int CNT_W  = 16
) (
  input logic              clock,
  input logic              reset,
  phase_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [3:0]        LAST_PH  = 4'(NPHASE - 1);
  localparam logic [NPHASE-1:0] BUS_ONE  = {{(NPHASE-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // state and datapath registers
  state_t            state_q,     state_d;
  logic [3:0]        phase_q,     phase_d;
  logic [NPHASE-1:0] phase_bus_q, phase_bus_d;
  logic              running_q,   running_d;
  logic              halted_q,    halted_d;
  logic              reset_ps_q,  reset_ps_d;
  logic [CNT_W-1:0]  icount_q,    icount_d;
  logic              stop_q,      stop_d;
  logic              restart_q,   restart_d;
  // one extra reset_ps cycle after reset is released
  logic              rst_pend_q;
  // previous samples for edge detection
  logic              exec_q;
  logic              step_q;

  logic exec_edge;
  logic step_edge;
  logic seq_active;
  logic advance;
  logic complete;

  // A request is a low-to-high transition against the previous registered sample.
  // Samples reset to 1 so a level already high across reset is never a request.
  assign exec_edge  = bus.exec & ~exec_q;
  assign step_edge  = bus.step & ~step_q;

  // halt and stall only matter while sequencing; IDLE and HALT never look at them
  assign seq_active = (state_q == S_RUN) || (state_q == S_STEP);
  assign advance    = seq_active & ~bus.stall;
  assign complete   = advance & (phase_q == LAST_PH);

  // State register: synchronous active-low reset abandons any instruction in flight
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      phase_q     <= 4'd0;
      phase_bus_q <= '0;
      running_q   <= 1'b0;
      halted_q    <= 1'b0;
      reset_ps_q  <= 1'b1;
      rst_pend_q  <= 1'b1;
      icount_q    <= '0;
      stop_q      <= 1'b0;
      restart_q   <= 1'b0;
      exec_q      <= 1'b1;
      step_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      phase_bus_q <= phase_bus_d;
      running_q   <= running_d;
      halted_q    <= halted_d;
      reset_ps_q  <= reset_ps_d;
      rst_pend_q  <= 1'b0;
      icount_q    <= icount_d;
      stop_q      <= stop_d;
      restart_q   <= restart_d;
      exec_q      <= bus.exec;
      step_q      <= bus.step;
    end
  end

  // Next-state logic: phase walk, completion handling, stop/halt/restart decisions
  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    icount_d  = icount_q;
    stop_d    = stop_q;
    restart_d = restart_q;

    unique case (state_q)
      S_IDLE: begin
        stop_d    = 1'b0;
        restart_d = 1'b0;
        // exec wins when both requests arrive together
        if (exec_edge) begin
          state_d = S_RUN;
          phase_d = 4'd0;
        end else if (step_edge) begin
          state_d = S_STEP;
          phase_d = 4'd0;
        end
      end

      S_RUN: begin
        // a stop request is remembered and acted on at the next completion
        if (exec_edge) begin
          stop_d = 1'b1;
        end
        if (advance) begin
          if (complete) begin
            icount_d = icount_q + CNT_ONE;
            phase_d  = 4'd0;
            if (bus.halt) begin
              state_d = S_HALT;
              stop_d  = 1'b0;
            end else if (stop_q || exec_edge) begin
              state_d = S_IDLE;
              stop_d  = 1'b0;
            end
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end
      end

      S_STEP: begin
        // exec and step edges are ignored while single-stepping
        if (advance) begin
          if (complete) begin
            icount_d = icount_q + CNT_ONE;
            phase_d  = 4'd0;
            state_d  = bus.halt ? S_HALT : S_IDLE;
          end else begin
            phase_d = phase_q + 4'd1;
          end
        end
      end

      S_HALT: begin
        phase_d = 4'd0;
        // restart spends one cycle in HALT with reset_ps high, then runs
        if (restart_q) begin
          state_d   = S_RUN;
          restart_d = 1'b0;
        end else if (exec_edge) begin
          restart_d = 1'b1;
          icount_d  = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        phase_d = 4'd0;
      end
    endcase
  end

  // Output logic: registered status derived from the next state so it lines up with phase
  always_comb begin
    running_d   = (state_d == S_RUN) || (state_d == S_STEP);
    halted_d    = (state_d == S_HALT);
    phase_bus_d = running_d ? (BUS_ONE << phase_d) : '0;
    reset_ps_d  = rst_pend_q | ((state_q == S_HALT) & ~restart_q & exec_edge);
  end

  assign bus.phase     = phase_q;
  assign bus.phase_bus = phase_bus_q;
  assign bus.reset_ps  = reset_ps_q;
  assign bus.running   = running_q;
  assign bus.halted    = halted_q;
  assign bus.icount    = icount_q;

  // phase strobes always agree with the binary phase while sequencing
  a_onehot: assert property (@(posedge clock) disable iff (!reset)
    running_q |-> (phase_bus_q == (BUS_ONE << phase_q)));

  // no strobes outside of RUN/STEP
  a_quiet: assert property (@(posedge clock) disable iff (!reset)
    !running_q |-> (phase_bus_q == '0));

  // running and halted are mutually exclusive
  a_excl: assert property (@(posedge clock) disable iff (!reset)
    !(running_q && halted_q));

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: run, stall, stop, halt/restart, reset, step, counter wrap.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// A second small instance (NPHASE=2, CNT_W=4) exercises counter wrap within a short run.
module tb_phase_sequencer;

  logic clock;
  logic reset;

  int checks;
  int failures;

  phase_sequencer_if #(.NPHASE(5), .CNT_W(16)) sif ();
  phase_sequencer_if #(.NPHASE(2), .CNT_W(4))  sif2 ();

  phase_sequencer #(.NPHASE(5), .CNT_W(16)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (sif.slave)
  );

  phase_sequencer #(.NPHASE(2), .CNT_W(4)) u_dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (sif2.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset     = 1'b0;
    sif.exec  = 1'b0; sif.step  = 1'b0; sif.halt  = 1'b0; sif.stall  = 1'b0;
    sif2.exec = 1'b0; sif2.step = 1'b0; sif2.halt = 1'b0; sif2.stall = 1'b0;

    // reset values
    ticks(2);
    chk("rst_phase",    32'(sif.phase),     32'd0);
    chk("rst_bus",      32'(sif.phase_bus), 32'd0);
    chk("rst_running",  32'(sif.running),   32'd0);
    chk("rst_halted",   32'(sif.halted),    32'd0);
    chk("rst_icount",   32'(sif.icount),    32'd0);
    chk("rst_reset_ps", 32'(sif.reset_ps),  32'd1);
    reset = 1'b1;
    tick();
    chk("rel_reset_ps_hi", 32'(sif.reset_ps), 32'd1);
    tick();
    chk("rel_reset_ps_lo", 32'(sif.reset_ps), 32'd0);

    // basic run: one-hot walk and first completion
    sif.exec = 1'b1;
    tick();
    chk("run_p0",      32'(sif.phase_bus), 32'b00001);
    chk("run_running", 32'(sif.running),   32'd1);
    sif.exec = 1'b0;
    tick(); chk("run_p1", 32'(sif.phase_bus), 32'b00010);
    tick(); chk("run_p2", 32'(sif.phase_bus), 32'b00100);
    tick(); chk("run_p3", 32'(sif.phase_bus), 32'b01000);
    tick(); chk("run_p4", 32'(sif.phase_bus), 32'b10000);
    chk("run_p4_phase",  32'(sif.phase),  32'd4);
    chk("run_p4_icount", 32'(sif.icount), 32'd0);
    tick(); chk("run_wrap", 32'(sif.phase_bus), 32'b00001);
    chk("run_icount1", 32'(sif.icount), 32'd1);

    // stall at phase 2 for three cycles
    ticks(2);
    chk("stall_pre", 32'(sif.phase_bus), 32'b00100);
    sif.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold", 32'(sif.phase_bus), 32'b00100);
    end
    sif.stall = 1'b0;
    tick(); chk("stall_p3", 32'(sif.phase_bus), 32'b01000);
    tick(); chk("stall_p4", 32'(sif.phase_bus), 32'b10000);
    chk("stall_icount_late", 32'(sif.icount), 32'd1);
    tick(); chk("stall_icount2", 32'(sif.icount), 32'd2);

    // stop request at phase 1
    tick(); chk("stop_p1", 32'(sif.phase), 32'd1);
    sif.exec = 1'b1;
    tick(); chk("stop_p2", 32'(sif.phase), 32'd2);
    sif.exec = 1'b0;
    ticks(2); chk("stop_p4", 32'(sif.phase_bus), 32'b10000);
    tick();
    chk("stop_running", 32'(sif.running),   32'd0);
    chk("stop_bus",     32'(sif.phase_bus), 32'd0);
    chk("stop_icount",  32'(sif.icount),    32'd3);

    // halt at completion, then restart via exec
    sif.exec = 1'b1;
    tick(); chk("h_start", 32'(sif.phase_bus), 32'b00001);
    sif.exec = 1'b0;
    ticks(3);
    sif.halt = 1'b1;
    tick();
    chk("h_p4",     32'(sif.phase_bus), 32'b10000);
    chk("h_p4_run", 32'(sif.running),   32'd1);
    tick();
    chk("h_halted",  32'(sif.halted),    32'd1);
    chk("h_running", 32'(sif.running),   32'd0);
    chk("h_bus",     32'(sif.phase_bus), 32'd0);
    chk("h_phase",   32'(sif.phase),     32'd0);
    chk("h_icount",  32'(sif.icount),    32'd4);
    sif.halt = 1'b0;
    tick(); chk("h_stay", 32'(sif.halted), 32'd1);
    sif.exec = 1'b1;
    tick();
    chk("h_rps",     32'(sif.reset_ps), 32'd1);
    chk("h_icount0", 32'(sif.icount),   32'd0);
    sif.exec = 1'b0;
    tick();
    chk("h_rps_lo",  32'(sif.reset_ps),  32'd0);
    chk("h_restart", 32'(sif.phase_bus), 32'b00001);
    chk("h_unhalt",  32'(sif.halted),    32'd0);

    // reset mid-instruction with exec held through release
    ticks(3);
    chk("mr_p3", 32'(sif.phase), 32'd3);
    reset    = 1'b0;
    sif.exec = 1'b1;
    tick();
    chk("mr_phase",   32'(sif.phase),     32'd0);
    chk("mr_bus",     32'(sif.phase_bus), 32'd0);
    chk("mr_running", 32'(sif.running),   32'd0);
    chk("mr_icount",  32'(sif.icount),    32'd0);
    chk("mr_rps",     32'(sif.reset_ps),  32'd1);
    reset = 1'b1;
    tick(); chk("mr_rel1_run", 32'(sif.running), 32'd0);
    tick(); chk("mr_rel2_run", 32'(sif.running), 32'd0);
    chk("mr_rel2_rps", 32'(sif.reset_ps), 32'd0);
    sif.exec = 1'b0;
    tick();

    // single step, step edge mid-instruction ignored
    sif.step = 1'b1;
    tick();
    chk("st_p0",  32'(sif.phase_bus), 32'b00001);
    chk("st_run", 32'(sif.running),   32'd1);
    sif.step = 1'b0;
    ticks(3);
    sif.step = 1'b1;
    tick();
    chk("st_p4",     32'(sif.phase_bus), 32'b10000);
    chk("st_p4_cnt", 32'(sif.icount),    32'd0);
    sif.step = 1'b0;
    tick();
    chk("st_done_run", 32'(sif.running),   32'd0);
    chk("st_done_bus", 32'(sif.phase_bus), 32'd0);
    chk("st_icount1",  32'(sif.icount),    32'd1);
    // second step with an exec edge inside it
    sif.step = 1'b1;
    tick();
    sif.step = 1'b0;
    tick();
    sif.exec = 1'b1;
    tick();
    sif.exec = 1'b0;
    ticks(2);
    chk("st2_p4", 32'(sif.phase_bus), 32'b10000);
    tick();
    chk("st2_run",    32'(sif.running), 32'd0);
    chk("st2_icount", 32'(sif.icount),  32'd2);

    // exec and step together: RUN wins, keeps going after completion
    sif.exec = 1'b1;
    sif.step = 1'b1;
    tick(); chk("co_p0", 32'(sif.phase_bus), 32'b00001);
    sif.exec = 1'b0;
    sif.step = 1'b0;
    ticks(5);
    chk("co_running", 32'(sif.running),   32'd1);
    chk("co_bus",     32'(sif.phase_bus), 32'b00001);
    chk("co_icount",  32'(sif.icount),    32'd3);
    sif.exec = 1'b1;
    tick();
    sif.exec = 1'b0;
    ticks(4);
    chk("co_stop_run", 32'(sif.running), 32'd0);
    chk("co_stop_cnt", 32'(sif.icount),  32'd4);

    // counter wrap on the small instance
    sif2.exec = 1'b1;
    tick();
    chk("w_p0",  32'(sif2.phase_bus), 32'b01);
    chk("w_run", 32'(sif2.running),   32'd1);
    sif2.exec = 1'b0;
    ticks(30);
    chk("w_max", 32'(sif2.icount), 32'hF);
    tick();
    chk("w_p1", 32'(sif2.phase_bus), 32'b10);
    tick();
    chk("w_wrap",  32'(sif2.icount),    32'h0);
    chk("w_p0_b",  32'(sif2.phase_bus), 32'b01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
